time_edit_engine: RTL and testbench
===================================

// Module: time_edit_engine
// PURPOSE
// Consumer side of the key manager: takes its EditMode/screen/EditPos state plus raw
// KEY presses and holds time (H:M:S), date (D-M-Y) and alarm registers. Runs time from
// a 1 Hz enable, applies Plus/Minus edits to the digit at EditPos, and drives 8 BCD
// digits plus a blank mask to the 7-segment driver.
// PARAMETERS
// DEBOUNCE_CYCLES  500000    clk cycles a key must read stable low before a press is accepted
// BLINK_CYCLES     12500000  half-period of the edited-digit blink
// PORTS
// clk        in   1   system clock
// reset      in   1   asynchronous, active-low reset
// tick_1hz   in   1   one-cycle 1 Hz enable
// EditMode   in   1   1 = edit active (from key manager)
// screen     in   2   0 time, 1 date, 2 alarm, 3 treated as 0
// EditPos    in   3   selected digit position
// Mode12t24  in   1   1 = 12h display, 0 = 24h
// KeyPlus    in   1   raw key, active-low
// KeyMinus   in   1   raw key, active-low
// digits     out  32  8 BCD nibbles; nibble i = display position i
// blank_mask out  8   bit i = 1 blanks position i
// alarm_hit  out  1   alarm enabled and hour/min equal to time
// BEHAVIOUR
// - Reset: time 00:00:00; date day 01, month 01, year 00; alarm 00:00, disabled; blink
//   phase 0; debounce counters 0; digits/blank_mask registered from these values.
// - Keys: 2-FF sync, then debounce. Stable low for DEBOUNCE_CYCLES gives one press pulse.
//   Re-arm only after a stable high. Presses act only when EditMode=1. Plus and Minus
//   pulsing in the same cycle are both ignored.
// - Edit takes effect on the cycle after the press pulse. digits update one cycle later.
// - Position map, screen 0, 24h: 0-1 sec ones/tens, 2-3 min, 4-5 hour 0..23, 6-7 blank.
// - Position map, screen 0, 12h: 0 AM/PM (nibble 0xA = AM, 0xB = PM), 1 blank,
//   2-3 sec, 4-5 min, 6-7 hour 1..12. Hour is stored 0..23 internally.
//   Hour 0 shows 12 AM; hour 13 shows 1 PM.
// - Position map, screen 1: 0-1 year 00..99, 2-3 month 1..12, 4-5 day 1..dim, 6-7 blank.
// - Position map, screen 2: 0-1 blank, 2-3 alarm min, 4-5 alarm hour (24h),
//   6 enable (0/1), 7 blank.
// - Edit rules for a field f in [min,max]:
//   - ones +: f = (f==max) ? min : f+1
//   - ones -: f = (f==min) ? max : f-1
//   - tens +: f = f+10; if the result is > max, f = max(f%10, min)
//   - tens -: f = f-10; if the result is < min, f = min(f%10 + 10*(max/10), max)
//   - AM/PM and alarm enable: either key toggles (hour +/-12).
//   - Presses on blank positions are ignored.
// - dim = days in month: Feb = 29 if year%4==0, else 28.
//   Any month/year edit clamps day to dim in the same update.
// - Run: tick_1hz with EditMode=0 advances sec. Carries go sec 59->0, min 59->0,
//   hour 23->0, then day dim->1, month 12->1, year 99->00.
//   Ticks are dropped while EditMode=1, so seconds freeze.
// - blank_mask: blank positions are always 1.
//   With EditMode=1, the bit at EditPos toggles every BLINK_CYCLES; other bits are 0.
// - alarm_hit is a level: enable & hour==alarm hour & min==alarm min.
//   It holds for that whole minute.
// - Reset asserted mid-edit or mid-debounce: all state returns to reset values immediately.
// TESTING
// 1. Reset then release: digits=0x??000000 blanks 6-7 (24h); time 00:00:00; alarm_hit=0.
// 2. Set 23:59:59 via edits, EditMode=0, one tick -> 00:00:00, day 01->02.
// 3. Date 28-02-23 (non-leap): tick at 23:59:59 -> 01-03-23.
//    Same with year 24 -> 29-02-24.
// 4. Edit screen 0, pos 5, hour 19, Plus -> 09 (29 invalid). Minus from 03 -> 23.
//    Pos 0, 24h, sec 59, Plus -> 00.
// 5. 12h mode, hour 13: digits pos7..6=0,1, pos0=0xB.
//    Press at pos 0 -> hour 1, pos0=0xA.
// 6. Key low for DEBOUNCE_CYCLES-1 then high: no edit.
//    Plus and Minus low together: no edit. Press with EditMode=0: no edit.

Source files
------------

// File: rtl/time_edit_engine_if.sv
// ---------------------------------------------------------------------------
// time_edit_engine_if
// Bundles the key-manager state, the raw keys and the 1 Hz enable that feed
// the time/date/alarm engine, together with the display outputs it returns.
//   master : key manager / display side (drives controls, reads display)
//   slave  : time_edit_engine
// Signals:
//   tick_1hz   one-cycle 1 Hz enable
//   EditMode   1 = edit active
//   screen     0 time, 1 date, 2 alarm, 3 treated as time
//   EditPos    selected digit position 0..7
//   Mode12t24  1 = 12h display, 0 = 24h display
//   KeyPlus    raw Plus key, active-low
//   KeyMinus   raw Minus key, active-low
//   digits     8 BCD nibbles, nibble i = display position i
//   blank_mask bit i = 1 blanks display position i
//   alarm_hit  alarm enabled and alarm hour/min equal current hour/min
// ---------------------------------------------------------------------------
interface time_edit_engine_if;
    logic        tick_1hz;
    logic        EditMode;
    logic [1:0]  screen;
    logic [2:0]  EditPos;
    logic        Mode12t24;
    logic        KeyPlus;
    logic        KeyMinus;
    logic [31:0] digits;
    logic [7:0]  blank_mask;
    logic        alarm_hit;

    modport master (
        output tick_1hz, EditMode, screen, EditPos, Mode12t24, KeyPlus, KeyMinus,
        input  digits, blank_mask, alarm_hit
    );

    modport slave (
        input  tick_1hz, EditMode, screen, EditPos, Mode12t24, KeyPlus, KeyMinus,
        output digits, blank_mask, alarm_hit
    );
endinterface

// File: rtl/time_edit_engine.sv
// ---------------------------------------------------------------------------
// time_edit_engine
// Holds the running time (H:M:S), the date (D-M-Y) and an alarm (H:M + enable).
// Time advances from a 1 Hz enable while not editing; Plus/Minus key presses
// edit the digit selected by EditPos on the current screen. Produces 8 BCD
// display nibbles, a blank mask (with blinking of the edited digit) and an
// alarm level.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   bus    time_edit_engine_if.slave (controls in, display out)
// Parameters:
//   DEBOUNCE_CYCLES  cycles a key must read stable before its level is accepted
//   BLINK_CYCLES     half-period of the edited-digit blink
// ---------------------------------------------------------------------------
module time_edit_engine #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_CYCLES    = 12500000
) (
    input  logic               clk,
    input  logic               reset,
    time_edit_engine_if.slave  bus
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BL_W = $clog2(BLINK_CYCLES + 1);

    // Generic bounded-field edit. Ones step with wrap; tens step by 10 and
    // fold back into [lo,hi] when they overshoot.
    function automatic logic [6:0] f_edit(input logic [6:0] f, input logic [6:0] lo,
                                          input logic [6:0] hi, input logic tens,
                                          input logic up);
        int fi, l, h, v;
        fi = int'(f);
        l  = int'(lo);
        h  = int'(hi);
        if (!tens) begin
            if (up) v = (fi == h) ? l : fi + 1;
            else    v = (fi == l) ? h : fi - 1;
        end else if (up) begin
            v = fi + 10;
            if (v > h) v = ((fi % 10) > l) ? (fi % 10) : l;
        end else begin
            v = fi - 10;
            if (v < l) begin
                v = (fi % 10) + 10 * (h / 10);
                if (v > h) v = h;
            end
        end
        return 7'(v);
    endfunction

    function automatic logic [4:0] f_dim(input logic [3:0] mon, input logic leap);
        case (mon)
            4'd2:                   return leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            default:                return 5'd31;
        endcase
    endfunction

    // Binary 0..99 to {tens, ones} BCD.
    function automatic logic [7:0] f_bcd(input logic [6:0] v);
        logic [3:0] t, o;
        t = 4'(v / 7'd10);
        o = 4'(v % 7'd10);
        return {t, o};
    endfunction

    // ---------------- key synchronisers and debouncers ----------------
    logic [1:0]      w_key_raw;
    logic [1:0]      r_key_s1, r_key_s2, r_key_state, r_press;
    logic [DB_W-1:0] r_db_cnt [2];

    assign w_key_raw = {bus.KeyMinus, bus.KeyPlus};

    // The debounced level only follows the synced key after it has held the
    // new value for DEBOUNCE_CYCLES; a press is the accepted high-to-low change,
    // so a new press needs an accepted high level first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key_s1    <= 2'b11;
            r_key_s2    <= 2'b11;
            r_key_state <= 2'b11;
            r_press     <= 2'b00;
            r_db_cnt[0] <= '0;
            r_db_cnt[1] <= '0;
        end else begin
            r_key_s1 <= w_key_raw;
            r_key_s2 <= r_key_s1;
            r_press  <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                if (r_key_s2[k] == r_key_state[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_db_cnt[k]    <= '0;
                    r_key_state[k] <= r_key_s2[k];
                    r_press[k]     <= ~r_key_s2[k];
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
                end
            end
        end
    end

    // ---------------- edit / run next-state ----------------
    logic [5:0] r_sec, r_min, r_al_min;
    logic [4:0] r_hour, r_al_hour, r_day;
    logic [3:0] r_mon;
    logic [6:0] r_year;
    logic       r_al_en;

    logic [5:0] w_sec_n, w_min_n, w_al_min_n;
    logic [4:0] w_hour_n, w_al_hour_n, w_day_n;
    logic [3:0] w_mon_n;
    logic [6:0] w_year_n;
    logic       w_al_en_n;
    logic [6:0] w_e;
    logic [4:0] w_dim, w_hmod_n;
    logic       w_plus, w_minus, w_edit, w_pm;
    logic [4:0] w_hmod, w_h12, w_dim_cur;
    logic [1:0] w_scr;

    assign w_plus    = r_press[0] & ~r_press[1] & bus.EditMode;
    assign w_minus   = r_press[1] & ~r_press[0] & bus.EditMode;
    assign w_edit    = w_plus | w_minus;
    assign w_scr     = (bus.screen == 2'd3) ? 2'd0 : bus.screen;
    assign w_pm      = (r_hour >= 5'd12);
    assign w_hmod    = w_pm ? (r_hour - 5'd12) : r_hour;
    assign w_h12     = (w_hmod == 5'd0) ? 5'd12 : w_hmod;
    assign w_dim_cur = f_dim(r_mon, r_year[1:0] == 2'b00);

    always_comb begin
        w_sec_n     = r_sec;
        w_min_n     = r_min;
        w_hour_n    = r_hour;
        w_day_n     = r_day;
        w_mon_n     = r_mon;
        w_year_n    = r_year;
        w_al_min_n  = r_al_min;
        w_al_hour_n = r_al_hour;
        w_al_en_n   = r_al_en;
        w_e         = '0;
        w_dim       = w_dim_cur;
        w_hmod_n    = '0;
        if (w_edit) begin
            case (w_scr)
                2'd1: begin
                    case (bus.EditPos)
                        3'd0, 3'd1: begin
                            w_e      = f_edit(r_year, 7'd0, 7'd99, bus.EditPos[0], w_plus);
                            w_year_n = w_e;
                        end
                        3'd2, 3'd3: begin
                            w_e     = f_edit({3'b0, r_mon}, 7'd1, 7'd12, bus.EditPos[0], w_plus);
                            w_mon_n = w_e[3:0];
                        end
                        3'd4, 3'd5: begin
                            w_e     = f_edit({2'b0, r_day}, 7'd1, {2'b0, w_dim_cur},
                                             bus.EditPos[0], w_plus);
                            w_day_n = w_e[4:0];
                        end
                        default: ;
                    endcase
                    // A month/year change must never leave an impossible day.
                    if (bus.EditPos < 3'd4) begin
                        w_dim = f_dim(w_mon_n, w_year_n[1:0] == 2'b00);
                        if (r_day > w_dim) w_day_n = w_dim;
                    end
                end
                2'd2: begin
                    case (bus.EditPos)
                        3'd2, 3'd3: begin
                            w_e        = f_edit({1'b0, r_al_min}, 7'd0, 7'd59, bus.EditPos[0], w_plus);
                            w_al_min_n = w_e[5:0];
                        end
                        3'd4, 3'd5: begin
                            w_e         = f_edit({2'b0, r_al_hour}, 7'd0, 7'd23, bus.EditPos[0], w_plus);
                            w_al_hour_n = w_e[4:0];
                        end
                        3'd6:    w_al_en_n = ~r_al_en;
                        default: ;
                    endcase
                end
                default: begin
                    if (!bus.Mode12t24) begin
                        case (bus.EditPos)
                            3'd0, 3'd1: begin
                                w_e     = f_edit({1'b0, r_sec}, 7'd0, 7'd59, bus.EditPos[0], w_plus);
                                w_sec_n = w_e[5:0];
                            end
                            3'd2, 3'd3: begin
                                w_e     = f_edit({1'b0, r_min}, 7'd0, 7'd59, bus.EditPos[0], w_plus);
                                w_min_n = w_e[5:0];
                            end
                            3'd4, 3'd5: begin
                                w_e      = f_edit({2'b0, r_hour}, 7'd0, 7'd23, bus.EditPos[0], w_plus);
                                w_hour_n = w_e[4:0];
                            end
                            default: ;
                        endcase
                    end else begin
                        case (bus.EditPos)
                            3'd0: w_hour_n = w_pm ? (r_hour - 5'd12) : (r_hour + 5'd12);
                            3'd2, 3'd3: begin
                                w_e     = f_edit({1'b0, r_sec}, 7'd0, 7'd59, bus.EditPos[0], w_plus);
                                w_sec_n = w_e[5:0];
                            end
                            3'd4, 3'd5: begin
                                w_e     = f_edit({1'b0, r_min}, 7'd0, 7'd59, bus.EditPos[0], w_plus);
                                w_min_n = w_e[5:0];
                            end
                            3'd6, 3'd7: begin
                                // Edit the displayed 1..12 value, keep the AM/PM half.
                                w_e      = f_edit({2'b0, w_h12}, 7'd1, 7'd12, bus.EditPos[0], w_plus);
                                w_hmod_n = (w_e[4:0] == 5'd12) ? 5'd0 : w_e[4:0];
                                w_hour_n = w_hmod_n + (w_pm ? 5'd12 : 5'd0);
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end else if (bus.tick_1hz && !bus.EditMode) begin
            if (r_sec != 6'd59) begin
                w_sec_n = r_sec + 6'd1;
            end else begin
                w_sec_n = '0;
                if (r_min != 6'd59) begin
                    w_min_n = r_min + 6'd1;
                end else begin
                    w_min_n = '0;
                    if (r_hour != 5'd23) begin
                        w_hour_n = r_hour + 5'd1;
                    end else begin
                        w_hour_n = '0;
                        if (r_day < w_dim_cur) begin
                            w_day_n = r_day + 5'd1;
                        end else begin
                            w_day_n = 5'd1;
                            if (r_mon != 4'd12) begin
                                w_mon_n = r_mon + 4'd1;
                            end else begin
                                w_mon_n  = 4'd1;
                                w_year_n = (r_year == 7'd99) ? 7'd0 : r_year + 7'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sec     <= '0;
            r_min     <= '0;
            r_hour    <= '0;
            r_day     <= 5'd1;
            r_mon     <= 4'd1;
            r_year    <= '0;
            r_al_min  <= '0;
            r_al_hour <= '0;
            r_al_en   <= 1'b0;
        end else begin
            r_sec     <= w_sec_n;
            r_min     <= w_min_n;
            r_hour    <= w_hour_n;
            r_day     <= w_day_n;
            r_mon     <= w_mon_n;
            r_year    <= w_year_n;
            r_al_min  <= w_al_min_n;
            r_al_hour <= w_al_hour_n;
            r_al_en   <= w_al_en_n;
        end
    end

    // ---------------- blink timer ----------------
    logic [BL_W-1:0] r_blink_cnt;
    logic            r_blink_phase;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == BL_W'(BLINK_CYCLES - 1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // ---------------- display formatting ----------------
    logic [31:0] w_digits, r_digits;
    logic [7:0]  w_blank_fixed, w_blank, r_blank;
    logic        r_alarm_hit;

    always_comb begin
        w_digits      = '0;
        w_blank_fixed = 8'hC0;
        case (w_scr)
            2'd1: w_digits = {8'h00, f_bcd({2'b0, r_day}), f_bcd({3'b0, r_mon}), f_bcd(r_year)};
            2'd2: begin
                w_digits      = {4'h0, 3'b000, r_al_en, f_bcd({2'b0, r_al_hour}),
                                 f_bcd({1'b0, r_al_min}), 8'h00};
                w_blank_fixed = 8'h83;
            end
            default: begin
                if (bus.Mode12t24) begin
                    w_digits      = {f_bcd({2'b0, w_h12}), f_bcd({1'b0, r_min}),
                                     f_bcd({1'b0, r_sec}), 4'h0, (w_pm ? 4'hB : 4'hA)};
                    w_blank_fixed = 8'h02;
                end else begin
                    w_digits = {8'h00, f_bcd({2'b0, r_hour}), f_bcd({1'b0, r_min}),
                                f_bcd({1'b0, r_sec})};
                end
            end
        endcase
        w_blank = w_blank_fixed;
        if (bus.EditMode && r_blink_phase) w_blank = w_blank_fixed | (8'b1 << bus.EditPos);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_digits    <= '0;
            r_blank     <= 8'hC0;
            r_alarm_hit <= 1'b0;
        end else begin
            r_digits    <= w_digits;
            r_blank     <= w_blank;
            r_alarm_hit <= r_al_en && (r_hour == r_al_hour) && (r_min == r_al_min);
        end
    end

    assign bus.digits     = r_digits;
    assign bus.blank_mask = r_blank;
    assign bus.alarm_hit  = r_alarm_hit;

endmodule

// File: tb/tb_time_edit_engine.sv
// ---------------------------------------------------------------------------
// tb_time_edit_engine
// Directed bench for time_edit_engine with short debounce/blink periods.
// Every expected display word is worked out by hand from the position maps.
// ---------------------------------------------------------------------------
module tb_time_edit_engine;

    localparam int DEB = 4;
    localparam int BLK = 8;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    time_edit_engine_if bus();

    time_edit_engine #(
        .DEBOUNCE_CYCLES(DEB),
        .BLINK_CYCLES   (BLK)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(3);
    endtask

    // Hold the selected keys low for 'hold' sampled edges, then release and
    // let the debouncer settle high again.
    task automatic press(input bit p, input bit m, input int hold);
        bus.KeyPlus  = ~p;
        bus.KeyMinus = ~m;
        wait_cyc(hold);
        bus.KeyPlus  = 1'b1;
        bus.KeyMinus = 1'b1;
        wait_cyc(DEB + 8);
    endtask

    task automatic edit(input logic [1:0] scr, input logic [2:0] pos, input bit up);
        bus.screen   = scr;
        bus.EditPos  = pos;
        bus.EditMode = 1'b1;
        press(up, ~up, DEB + 4);
    endtask

    task automatic tick();
        bus.EditMode = 1'b0;
        wait_cyc(2);
        bus.tick_1hz = 1'b1;
        wait_cyc(1);
        bus.tick_1hz = 1'b0;
        wait_cyc(3);
    endtask

    task automatic set_235959();
        edit(2'd0, 3'd4, 1'b0);
        edit(2'd0, 3'd2, 1'b0);
        edit(2'd0, 3'd0, 1'b0);
    endtask

    initial begin
        bit         seen_hi, seen_lo;
        logic [7:0] others;
        errors = 0;
        checks = 0;
        reset         = 1'b0;
        bus.tick_1hz  = 1'b0;
        bus.EditMode  = 1'b0;
        bus.screen    = 2'd0;
        bus.EditPos   = 3'd0;
        bus.Mode12t24 = 1'b0;
        bus.KeyPlus   = 1'b1;
        bus.KeyMinus  = 1'b1;
        do_reset();

        // Reset state
        chk("rst_digits", {8'h00, bus.digits[23:0]}, 32'h0);
        chk("rst_blank", {24'h0, bus.blank_mask}, 32'hC0);
        chk("rst_alarm", {31'h0, bus.alarm_hit}, 32'h0);

        // Midnight rollover with day carry
        set_235959();
        chk("set_235959", bus.digits, 32'h00235959);
        tick();
        chk("wrap_time", bus.digits, 32'h00000000);
        bus.screen = 2'd1;
        wait_cyc(3);
        chk("wrap_date", bus.digits, 32'h00020100);

        // Month end, non-leap then leap February
        do_reset();
        edit(2'd1, 3'd1, 1'b1);
        edit(2'd1, 3'd1, 1'b1);
        repeat (3) edit(2'd1, 3'd0, 1'b1);
        edit(2'd1, 3'd2, 1'b1);
        edit(2'd1, 3'd4, 1'b0);
        chk("date_280223", bus.digits, 32'h00280223);
        set_235959();
        tick();
        bus.screen = 2'd1;
        wait_cyc(3);
        chk("nonleap_feb", bus.digits, 32'h00010323);
        edit(2'd1, 3'd0, 1'b1);
        edit(2'd1, 3'd2, 1'b0);
        edit(2'd1, 3'd4, 1'b0);
        chk("leap_dim", bus.digits, 32'h00290224);
        edit(2'd1, 3'd4, 1'b0);
        set_235959();
        tick();
        bus.screen = 2'd1;
        wait_cyc(3);
        chk("leap_feb", bus.digits, 32'h00290224);
        edit(2'd1, 3'd0, 1'b1);
        chk("year_clamp", bus.digits, 32'h00280225);

        // Hour tens/ones rules and seconds wrap (24h)
        do_reset();
        edit(2'd0, 3'd5, 1'b0);
        edit(2'd0, 3'd4, 1'b0);
        chk("hour19", bus.digits, 32'h00190000);
        edit(2'd0, 3'd5, 1'b1);
        chk("hour_tens_plus", bus.digits, 32'h00090000);
        repeat (6) edit(2'd0, 3'd4, 1'b0);
        chk("hour03", bus.digits, 32'h00030000);
        edit(2'd0, 3'd5, 1'b0);
        chk("hour_tens_minus", bus.digits, 32'h00230000);
        edit(2'd0, 3'd0, 1'b0);
        chk("sec59", bus.digits, 32'h00230059);
        edit(2'd0, 3'd0, 1'b1);
        chk("sec_wrap", bus.digits, 32'h00230000);

        // 12h display and AM/PM toggle
        edit(2'd0, 3'd5, 1'b0);
        bus.Mode12t24 = 1'b1;
        bus.EditMode  = 1'b0;
        wait_cyc(3);
        chk("12h_pm", bus.digits, 32'h0100000B);
        chk("12h_blank", {24'h0, bus.blank_mask}, 32'h02);
        edit(2'd0, 3'd0, 1'b1);
        chk("12h_am", bus.digits, 32'h0100000A);
        edit(2'd0, 3'd6, 1'b0);
        chk("12h_midnight", bus.digits, 32'h1200000A);

        // Alarm enable and match level
        edit(2'd2, 3'd6, 1'b1);
        chk("alarm_digits", bus.digits, 32'h01000000);
        chk("alarm_hit_on", {31'h0, bus.alarm_hit}, 32'h1);
        edit(2'd0, 3'd4, 1'b1);
        chk("12h_min", bus.digits, 32'h1201000A);
        chk("alarm_hit_off", {31'h0, bus.alarm_hit}, 32'h0);

        // Blink of edited position only
        bus.Mode12t24 = 1'b0;
        bus.screen    = 2'd0;
        bus.EditPos   = 3'd0;
        bus.EditMode  = 1'b1;
        seen_hi = 1'b0;
        seen_lo = 1'b0;
        others  = '0;
        repeat (3 * BLK) begin
            wait_cyc(1);
            if (bus.blank_mask[0]) seen_hi = 1'b1;
            else                   seen_lo = 1'b1;
            others = others | (bus.blank_mask & 8'h3E);
        end
        chk("blink_toggle", {30'h0, seen_hi, seen_lo}, 32'h3);
        chk("blink_others", {24'h0, others}, 32'h0);

        // Rejected presses
        chk("pre_reject", bus.digits, 32'h00000100);
        press(1'b1, 1'b0, DEB - 1);
        chk("short_press", bus.digits, 32'h00000100);
        press(1'b1, 1'b1, DEB + 4);
        chk("both_keys", bus.digits, 32'h00000100);
        bus.EditMode = 1'b0;
        press(1'b1, 1'b0, DEB + 4);
        chk("editmode_off", bus.digits, 32'h00000100);
        edit(2'd0, 3'd0, 1'b1);
        chk("press_after", bus.digits, 32'h00000101);

        // Asynchronous reset in the middle of a debounce
        bus.KeyPlus = 1'b0;
        wait_cyc(2);
        reset = 1'b0;
        #1;
        chk("async_rst_digits", bus.digits, 32'h0);
        chk("async_rst_blank", {24'h0, bus.blank_mask}, 32'hC0);
        bus.KeyPlus  = 1'b1;
        bus.EditMode = 1'b0;
        wait_cyc(2);
        reset = 1'b1;
        wait_cyc(DEB + 8);
        chk("after_rst", bus.digits, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
